// File: rtl/pixel_frame_loader_if.sv
// Pixel-stream / frame-hold bus between a pixel source, the frame loader and the consuming layer.
interface pixel_frame_loader_if #(
    parameter int dataWidth  = 16,
    parameter int numInputs  = 784,
    parameter int pixelWidth = 8
);
    localparam int cntWidth = $clog2(numInputs + 1);

    // Handshake: a pixel transfers on a rising edge where pixelValid and pixelReady are both 1.
    // frameValid holds frameOut stable until the consumer pulses frameDone.
    logic [pixelWidth-1:0]           pixelIn;
    logic                            pixelValid;
    logic                            pixelFirst;
    logic                            pixelReady;
    logic                            frameDone;
    logic [dataWidth*numInputs-1:0]  frameOut;
    logic                            frameValid;
    logic [cntWidth-1:0]             pixelCount;

    modport master (
        output pixelIn, pixelValid, pixelFirst, frameDone,
        input  pixelReady, frameOut, frameValid, pixelCount
    );

    modport slave (
        input  pixelIn, pixelValid, pixelFirst, frameDone,
        output pixelReady, frameOut, frameValid, pixelCount
    );
endinterface

// File: rtl/pixel_frame_loader.sv
// Collects a frame of pixels into fixed-point elements, then holds the frame until the consumer releases it.
module pixel_frame_loader #(
    parameter int dataWidth  = 16,
    parameter int numInputs  = 784,
    parameter int pixelWidth = 8,
    parameter int fracWidth  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    pixel_frame_loader_if.slave     pix_if,
    output logic                    state_o
);
    localparam int cntWidth = $clog2(numInputs + 1);
    localparam int shiftAmt = fracWidth - pixelWidth;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

    state_e                          state_q, state_d;
    logic [cntWidth-1:0]             count_q, count_d;
    logic [dataWidth*numInputs-1:0]  frame_q, frame_d;
    logic                            valid_q, valid_d;

    logic                            ready;
    logic                            accept;
    logic [cntWidth-1:0]             slot;
    logic [dataWidth-1:0]            elem;

    // Pixel p becomes p / 2^pixelWidth in the element's fixed-point format.
    assign elem   = dataWidth'(pix_if.pixelIn) << shiftAmt;
    assign ready  = (state_q == COLLECT) && !reset;
    assign accept = ready && pix_if.pixelValid;
    assign slot   = pix_if.pixelFirst ? '0 : count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        frame_d = frame_q;
        valid_d = valid_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int k = 0; k < numInputs; k++) begin
                        if (int'(slot) == k) frame_d[k*dataWidth +: dataWidth] = elem;
                    end
                    // A resync marker restarts the frame; stale slots get overwritten later.
                    if (slot == cntWidth'(numInputs - 1)) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        count_d = cntWidth'(numInputs);
                    end else begin
                        count_d = slot + cntWidth'(1);
                    end
                end
            end
            HOLD: begin
                if (pix_if.frameDone) begin
                    state_d = COLLECT;
                    valid_d = 1'b0;
                    count_d = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            count_q <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

    assign pix_if.pixelReady = ready;
    assign pix_if.frameOut   = frame_q;
    assign pix_if.frameValid = valid_q;
    assign pix_if.pixelCount = count_q;
    assign state_o           = state_q;
endmodule

// File: doc/pixel_frame_loader.md
PIXEL_FRAME_LOADER -- requirements
Module: pixel_frame_loader

Interface
REQ-001 SHALL have parameter dataWidth, default 16, width of one frame element (Q6.10, unsigned use).
REQ-002 SHALL have parameter numInputs, default 784, pixels per frame.
REQ-003 SHALL have parameter pixelWidth, default 8, width of one incoming pixel.
REQ-004 SHALL have parameter fracWidth, default 10, fractional bits of the output element; fracWidth >= pixelWidth.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pixelIn, input, pixelWidth: unsigned pixel sample.
REQ-008 SHALL have port pixelValid, input, 1: pixelIn is valid this cycle.
REQ-009 SHALL have port pixelFirst, input, 1: the current pixel is frame index 0 (resync marker).
REQ-010 SHALL have port pixelReady, output, 1: the loader accepts a pixel this cycle.
REQ-011 SHALL have port frameDone, input, 1: the consumer has finished with the held frame (driven from the layer output-valid).
REQ-012 SHALL have port frameOut, output, dataWidth*numInputs: assembled frame; element k at bits [(k+1)*dataWidth-1 -: dataWidth].
REQ-013 SHALL have port frameValid, output, 1: frameOut is complete and stable (drives the layer's input-valid).
REQ-014 SHALL have port pixelCount, output, $clog2(numInputs+1): pixels stored so far in the current frame.

Function
REQ-015 SHALL implement a two-state FSM: COLLECT and HOLD.
REQ-016 SHALL drive pixelReady = 1 exactly when state is COLLECT and reset is low; pixelReady is 0 in HOLD.
REQ-017 SHALL accept a pixel in a cycle when pixelValid and pixelReady are both 1; no pixel is accepted otherwise.
REQ-018 SHALL convert an accepted pixel to an element by zero-extending it and shifting it left by (fracWidth - pixelWidth): 8-bit p gives p*4, i.e. p/256 in Q6.10.
REQ-019 SHALL write an accepted pixel without pixelFirst to slot pixelCount and increment pixelCount.
REQ-020 SHALL write an accepted pixel with pixelFirst to slot 0 and set pixelCount to 1, at any count (mid-frame resync); stale slots are overwritten later.
REQ-021 SHALL, when the accepted pixel fills slot numInputs-1, move to HOLD, set frameValid = 1 and set pixelCount = numInputs on the next edge.
REQ-022 SHALL, when numInputs = 1 and the accepted pixel carries pixelFirst, treat that pixel as the last pixel of the frame.
REQ-023 SHALL keep frameOut, pixelCount and frameValid unchanged in HOLD until frameDone = 1.
REQ-024 SHALL, on frameDone = 1 in HOLD, move to COLLECT, clear frameValid and clear pixelCount to 0 on the next edge; frameOut keeps its contents.
REQ-025 SHALL ignore frameDone in COLLECT, and SHALL ignore pixelValid in HOLD; an ignored pixel is not stored.
REQ-026 SHALL register frameValid, so it rises one cycle after the final pixel is accepted; the earliest a new pixel can be accepted is one cycle after frameDone is sampled.
REQ-027 SHALL keep pixelCount in the range 0..numInputs at all times.

Reset
REQ-028 SHALL, on a clock edge with reset = 1, set state to COLLECT, pixelCount to 0, frameValid to 0 and every frameOut bit to 0, regardless of state (including mid-frame and HOLD).
REQ-029 SHALL accept no pixel on a clock edge with reset = 1.

Verification (numInputs = 4 unless stated)
REQ-030 SHALL pass: after reset, stream pixels 0x00, 0x01, 0x80, 0xFF with pixelFirst on the first -> frameValid rises on the cycle after 0xFF; frameOut = {0x03FC, 0x0200, 0x0004, 0x0000} (element 3 down to element 0); pixelReady = 0.
REQ-031 SHALL pass: in HOLD, drive pixelValid = 1 for 5 cycles with new data -> frameOut and pixelCount = 4 unchanged; pixelReady stays 0.
REQ-032 SHALL pass: in HOLD, pulse frameDone for 1 cycle -> frameValid = 0 and pixelCount = 0 on the next cycle; pixelReady = 1; the next frame is accepted starting at slot 0.
REQ-033 SHALL pass: send 2 pixels, then 0x10 with pixelFirst, then 3 more -> the frame completes after those 3 more pixels; element 0 = 0x0040; no early frameValid.
REQ-034 SHALL pass: assert reset for one cycle when pixelCount = 3, and separately when in HOLD -> pixelCount = 0, frameValid = 0, frameOut = 0, pixelReady = 1 after reset.
REQ-035 SHALL pass: pulse frameDone in COLLECT with pixelCount = 2 -> no state change; pixelCount stays 2.
